// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial two's-complement subtractor, diff = a - b, LSB first
// Optional signed-overflow output ovf enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout
`ifdef SERIAL_SUB_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] sreg_a_q, sreg_a_d;
   logic [WIDTH-1:0] sreg_b_q, sreg_b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             borrow_q, borrow_d;
   logic             bout_q, bout_d;
`ifdef SERIAL_SUB_OVF_EN
   logic             ovf_q, ovf_d;
`endif

   logic a0, b0, dbit, bnext;

   // Full-subtractor cell on the current LSBs.
   assign a0    = sreg_a_q[0];
   assign b0    = sreg_b_q[0];
   assign dbit  = a0 ^ b0 ^ borrow_q;
   assign bnext = (~a0 & b0) | (~(a0 ^ b0) & borrow_q);

   always_comb begin
      state_d  = state_q;
      sreg_a_d = sreg_a_q;
      sreg_b_d = sreg_b_q;
      res_d    = res_q;
      diff_d   = diff_q;
      cnt_d    = cnt_q;
      borrow_d = borrow_q;
      bout_d   = bout_q;
`ifdef SERIAL_SUB_OVF_EN
      ovf_d    = ovf_q;
`endif
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               sreg_a_d = a;
               sreg_b_d = b;
               borrow_d = 1'b0;
               cnt_d    = '0;
               state_d  = S_RUN;
            end else begin
               state_d  = S_IDLE;
            end
         end
         S_RUN: begin
            sreg_a_d = {1'b0, sreg_a_q[WIDTH-1:1]};
            sreg_b_d = {1'b0, sreg_b_q[WIDTH-1:1]};
            res_d    = {dbit, res_q[WIDTH-1:1]};
            borrow_d = bnext;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               diff_d  = {dbit, res_q[WIDTH-1:1]};
               bout_d  = bnext;
`ifdef SERIAL_SUB_OVF_EN
               // On the final bit a0/b0 are the operand sign bits and dbit is the result sign.
               ovf_d   = (a0 != b0) && (dbit != a0);
`endif
               state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         sreg_a_q <= '0;
         sreg_b_q <= '0;
         res_q    <= '0;
         diff_q   <= '0;
         cnt_q    <= '0;
         borrow_q <= 1'b0;
         bout_q   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
         ovf_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         sreg_a_q <= sreg_a_d;
         sreg_b_q <= sreg_b_d;
         res_q    <= res_d;
         diff_q   <= diff_d;
         cnt_q    <= cnt_d;
         borrow_q <= borrow_d;
         bout_q   <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
         ovf_q    <= ovf_d;
`endif
      end
   end

   assign busy = (state_q == S_RUN);
   assign done = (state_q == S_DONE);
   assign diff = diff_q;
   assign bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
   assign ovf  = ovf_q;
`endif

endmodule
